image_read_arbiter: RTL and testbench
=====================================

# image_read_arbiter

Shares the single read port of the image pixel store between the VGA display scan and an auxiliary requester (overlay/sprite engine or debug readback). The display scan gets a fixed-latency pixel stream with strict priority. The auxiliary port uses a request/grant and valid/ready handshake and is serviced in slots the display leaves free. The block converts display (H, V) coordinates to a linear store index, masks out-of-image coordinates, and drives the store's enable, address and read-data path.

## Interface
- IMG_W, 640, image width in pixels
- IMG_H, 60, image height in lines
- ADDR_W, 16, linear store index width
- PIX_W, 12, pixel width (4:4:4 RGB)
- STARVE_LIMIT, 15, consecutive lost aux slots before forced aux grant (guard build only)

- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- disp_req  in  1  display wants a pixel this cycle
- disp_haddr  in  11  display horizontal pixel address
- disp_vaddr  in  11  display vertical pixel address
- disp_pixel  out  PIX_W  pixel returned to display
- disp_pvalid  out  1  disp_pixel updated this cycle
- disp_miss  out  1  pixel slot given to aux; disp_pixel repeats the previous value
- aux_req  in  1  aux read request
- aux_addr  in  ADDR_W  aux linear index
- aux_gnt  out  1  aux request accepted this cycle
- aux_rvalid  out  1  aux read data valid
- aux_rdata  out  PIX_W  aux read data
- aux_err  out  1  with aux_rvalid: index was out of range, data is 0
- aux_rready  in  1  aux consumer accepts data
- mem_en  out  1  store read enable
- mem_addr  out  ADDR_W  store read index
- mem_rdata  in  PIX_W  store data; valid one cycle after mem_en

## Operation
- Display index = disp_vaddr*IMG_W + disp_haddr, computed at full width and truncated to ADDR_W. In range only if disp_haddr < IMG_W and disp_vaddr < IMG_H.
- Arbitration per cycle:
  - If disp_req is asserted and the coordinate is in range, display owns the port.
  - Otherwise the port is free for aux.
  - An out-of-range display request consumes no memory slot and returns 0.
- Aux FSM:
  - IDLE: if aux_req and the port is free, assert aux_gnt, latch the index and go to READ. If aux_req and the port is busy, go to WAIT.
  - WAIT: grant on the first free slot, then go to READ.
  - READ: data is captured next cycle. Go to RESP.
  - RESP: hold aux_rvalid/aux_rdata/aux_err stable until aux_rready. Return to IDLE the same cycle aux_rready is seen.
- An aux index ≥ IMG_W*IMG_H is granted without mem_en and completes with aux_rdata = 0 and aux_err = 1.
- Only one aux transaction is outstanding. aux_gnt is never asserted outside IDLE/WAIT.
- Reset values: disp_pixel 0, disp_pvalid 0, disp_miss 0, aux_gnt 0, aux_rvalid 0, aux_rdata 0, aux_err 0, mem_en 0, mem_addr 0, FSM in IDLE, starvation counter 0.
- Reset mid-transaction drops the in-flight aux read. No aux_rvalid is produced for it.

## Timing
- Display request sampled at edge T: mem_en/mem_addr registered at T, mem_rdata sampled at T+1, disp_pixel/disp_pvalid registered at T+1. Latency is 2 edges, at a throughput of one pixel per clock.
- Out-of-range display request: disp_pixel = 0 with disp_pvalid, at the same 2-edge latency as in-range requests.
- Aux, port free: aux_gnt combinational in the request cycle. aux_rvalid rises 2 edges after the grant edge.
- Simultaneous in-range disp_req and aux_req: display wins and aux moves to WAIT, unless the guard forces aux (see Configuration).
- aux_rready held high continuously: one aux read every 3 cycles at most.

## Configuration
- STARVE_GUARD_EN defined:
  - A counter increments each cycle the aux FSM is in WAIT and the port is denied.
  - When the count reaches STARVE_LIMIT, the next slot goes to aux.
  - The display request in that slot gets disp_pvalid=1 with disp_miss=1 and disp_pixel equal to its previous value, at the normal latency.
  - The counter clears on each aux grant.
- STARVE_GUARD_EN undefined: display always wins, disp_miss is tied to 0, and no counter is implemented.

## Test plan
- Reset, then disp_req held with (H,V) = (5,2) → mem_addr = 1285, and disp_pixel = store[1285] with disp_pvalid 2 edges later; all outputs 0 during reset.
- disp_req with H=640 or V=60 → mem_en stays 0, and disp_pixel = 0 with disp_pvalid after 2 edges.
- disp_req low, aux_req with aux_addr=100, aux_rready low for 4 cycles → aux_gnt the same cycle; aux_rvalid with store[100] held stable until aux_rready, then IDLE.
- aux_req with aux_addr=38400 → aux_rvalid, aux_err=1, aux_rdata=0, with no mem_en.
- Continuous in-range disp_req plus aux_req, with STARVE_GUARD_EN → aux granted after 15 denied cycles, one disp_miss pulse with a repeated pixel. Without the guard → aux waits until disp_req drops.
- rst asserted during aux READ → no aux_rvalid afterwards; the next aux_req completes normally.

Source files
------------

// File: rtl/image_read_arbiter.sv
// rtl/image_read_arbiter.sv - display/aux arbiter for the image pixel store read port
//
// Purpose:
//   Shares one synchronous-read pixel store between the VGA display scan
//   and an auxiliary requester. The display scan has strict priority and gets
//   a fixed two-edge pixel latency at one pixel per clock. The aux port
//   uses aux_req/aux_gnt to place a request and aux_rvalid/aux_rready to
//   return the data. It is serviced only in cycles the display leaves free.
//
// Optional build macro:
//   STARVE_GUARD_EN - when defined, an aux request that keeps losing slots
//                     gets a forced slot after STARVE_LIMIT denied WAIT
//                     cycles. The displaced display pixel is flagged with
//                     disp_miss and repeats the previous pixel. When the
//                     macro is undefined, disp_miss is tied to 0.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   disp_req                 display wants a pixel this cycle
//   disp_haddr, disp_vaddr   display pixel coordinates
//   disp_pixel, disp_pvalid  returned pixel and its strobe (2-edge latency)
//   disp_miss                pixel slot was given to aux; pixel repeated
//   aux_req, aux_addr        aux request and linear index
//   aux_gnt                  combinational grant in the request cycle
//   aux_rvalid, aux_rdata    aux response, held until aux_rready
//   aux_err                  aux index was outside the image; data is 0
//   aux_rready               aux consumer accepts the response
//   mem_en, mem_addr         registered store read enable and index
//   mem_rdata                store data, valid in the cycle mem_en is high

module image_read_arbiter #(
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 60,
    parameter int ADDR_W = 16,
    parameter int PIX_W  = 12
`ifdef STARVE_GUARD_EN
    ,
    parameter int STARVE_LIMIT = 15
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              disp_req,
    input  logic [10:0]       disp_haddr,
    input  logic [10:0]       disp_vaddr,
    output logic [PIX_W-1:0]  disp_pixel,
    output logic              disp_pvalid,
    output logic              disp_miss,
    input  logic              aux_req,
    input  logic [ADDR_W-1:0] aux_addr,
    output logic              aux_gnt,
    output logic              aux_rvalid,
    output logic [PIX_W-1:0]  aux_rdata,
    output logic              aux_err,
    input  logic              aux_rready,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [PIX_W-1:0]  mem_rdata
);

    localparam int IMG_SIZE = IMG_W * IMG_H;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_READ,
        S_RESP
    } aux_state_t;

    aux_state_t        aux_state;

    logic              disp_in_range;
    logic [ADDR_W-1:0] disp_idx;
    logic              disp_own;
    logic              aux_in_range;
    logic              aux_forced;

    // Display stage between the address edge and the data edge:
    // d_req  - a display request was taken (always answered)
    // d_hit  - that request read the store
    logic              d_req;
    logic              d_hit;

    // Aux index was outside the image: the response is an error with 0 data
    logic              a_err;

`ifdef STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0]  starve_cnt;
    // The display request in the forced slot was displaced
    logic              d_miss;

    assign aux_forced = (aux_state == S_WAIT) && (starve_cnt == CNT_W'(STARVE_LIMIT));
`else
    assign aux_forced = 1'b0;
    assign disp_miss  = 1'b0;
`endif

    // The index is computed at full width, then truncated to the store index width
    assign disp_idx      = ADDR_W'(int'(disp_vaddr) * IMG_W + int'(disp_haddr));
    assign disp_in_range = (int'(disp_haddr) < IMG_W) && (int'(disp_vaddr) < IMG_H);
    assign aux_in_range  = int'(aux_addr) < IMG_SIZE;

    // An out-of-range display request uses no store slot. That slot stays free for aux.
    assign disp_own = disp_req && disp_in_range && !aux_forced;

    always_comb begin
        aux_gnt = 1'b0;
        if (!rst && !disp_own) begin
            if ((aux_state == S_IDLE && aux_req) || aux_state == S_WAIT) begin
                aux_gnt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            aux_state   <= S_IDLE;
            mem_en      <= 1'b0;
            mem_addr    <= '0;
            d_req       <= 1'b0;
            d_hit       <= 1'b0;
            disp_pixel  <= '0;
            disp_pvalid <= 1'b0;
            aux_rvalid  <= 1'b0;
            aux_rdata   <= '0;
            aux_err     <= 1'b0;
            a_err       <= 1'b0;
`ifdef STARVE_GUARD_EN
            starve_cnt  <= '0;
            d_miss      <= 1'b0;
            disp_miss   <= 1'b0;
`endif
        end else begin
            // Store port: the display has priority. Aux gets the port only in its grant cycle.
            mem_en <= 1'b0;
            if (disp_own) begin
                mem_en   <= 1'b1;
                mem_addr <= disp_idx;
            end else if (aux_gnt && aux_in_range) begin
                mem_en   <= 1'b1;
                mem_addr <= aux_addr;
            end

            // Display return path, one edge after the address edge
            d_req       <= disp_req;
            d_hit       <= disp_own;
            disp_pvalid <= d_req;
            if (d_req) begin
                if (d_hit) begin
                    disp_pixel <= mem_rdata;
`ifdef STARVE_GUARD_EN
                end else if (!d_miss) begin
                    disp_pixel <= '0;
                end
`else
                end else begin
                    disp_pixel <= '0;
                end
`endif
            end

`ifdef STARVE_GUARD_EN
            d_miss    <= disp_req && disp_in_range && aux_forced;
            disp_miss <= d_miss;

            if (aux_gnt) begin
                starve_cnt <= '0;
            end else if (aux_state == S_WAIT) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
`endif

            case (aux_state)
                S_IDLE: begin
                    if (aux_gnt) begin
                        a_err     <= !aux_in_range;
                        aux_state <= S_READ;
                    end else if (aux_req) begin
                        aux_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (aux_gnt) begin
                        a_err     <= !aux_in_range;
                        aux_state <= S_READ;
                    end
                end
                S_READ: begin
                    aux_rvalid <= 1'b1;
                    aux_rdata  <= a_err ? '0 : mem_rdata;
                    aux_err    <= a_err;
                    aux_state  <= S_RESP;
                end
                S_RESP: begin
                    if (aux_rready) begin
                        aux_rvalid <= 1'b0;
                        aux_state  <= S_IDLE;
                    end
                end
                default: aux_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_image_read_arbiter.sv
// tb/tb_image_read_arbiter.sv - self-checking bench for image_read_arbiter

module tb_image_read_arbiter;

    localparam int NPIX = 38400;

    logic        clk = 1'b0;
    logic        rst;
    logic        disp_req;
    logic [10:0] disp_haddr;
    logic [10:0] disp_vaddr;
    logic [11:0] disp_pixel;
    logic        disp_pvalid;
    logic        disp_miss;
    logic        aux_req;
    logic [15:0] aux_addr;
    logic        aux_gnt;
    logic        aux_rvalid;
    logic [11:0] aux_rdata;
    logic        aux_err;
    logic        aux_rready;
    logic        mem_en;
    logic [15:0] mem_addr;
    logic [11:0] mem_rdata;

    logic [11:0] store [0:NPIX-1];

    // Store data for the address held in the current cycle. Unexpected reads return a marker value.
    assign mem_rdata = (mem_en && mem_addr < 16'(NPIX)) ? store[mem_addr] : 12'hBAD;

    always #5 clk = ~clk;

    image_read_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .disp_req    (disp_req),
        .disp_haddr  (disp_haddr),
        .disp_vaddr  (disp_vaddr),
        .disp_pixel  (disp_pixel),
        .disp_pvalid (disp_pvalid),
        .disp_miss   (disp_miss),
        .aux_req     (aux_req),
        .aux_addr    (aux_addr),
        .aux_gnt     (aux_gnt),
        .aux_rvalid  (aux_rvalid),
        .aux_rdata   (aux_rdata),
        .aux_err     (aux_err),
        .aux_rready  (aux_rready),
        .mem_en      (mem_en),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: the previous display request, the aux transaction, and the expected outputs
    bit          p_req, p_hit, p_miss;
    int          p_idx;
    logic [11:0] e_pix = '0;
    bit          e_pvalid, e_miss, e_men;
    logic [15:0] e_maddr = '0;
    bit          m_busy, m_resp, m_wait, m_err;
    int          m_denied;
    logic [15:0] m_addr = '0;
    logic [11:0] e_rdata = '0;
    bit          e_err;
    bit          last_gnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: check the combinational grant, update the model, then check the registered outputs.
    task automatic cycle();
        bit in_r, forced, own, gnt_e, busy0;
        int idx;
        #1;
        in_r   = (int'(disp_haddr) < 640) && (int'(disp_vaddr) < 60);
        idx    = int'(disp_vaddr) * 640 + int'(disp_haddr);
        forced = 1'b0;
`ifdef STARVE_GUARD_EN
        forced = m_wait && (m_denied == 15);
`endif
        own   = disp_req && in_r && !forced;
        busy0 = m_busy;
        gnt_e = !rst && !busy0 && (aux_req || m_wait) && !own;
        chk("aux_gnt", 32'(aux_gnt), 32'(gnt_e));
        last_gnt = aux_gnt;

        if (rst) begin
            p_req = 0; p_hit = 0; p_miss = 0;
            e_pix = '0; e_pvalid = 0; e_miss = 0; e_men = 0; e_maddr = '0;
            m_busy = 0; m_resp = 0; m_wait = 0; m_denied = 0;
            e_rdata = '0; e_err = 0;
        end else begin
            e_pvalid = p_req;
            e_miss   = p_miss;
            if (p_req && !p_miss) e_pix = p_hit ? store[p_idx] : 12'h000;
            p_req  = disp_req;
            p_hit  = own;
            p_miss = disp_req && in_r && forced;
            p_idx  = idx;

            e_men = own || (gnt_e && aux_addr < 16'(NPIX));
            if (own) e_maddr = 16'(idx);
            else if (e_men) e_maddr = aux_addr;

            if (busy0) begin
                if (!m_resp) begin
                    m_resp  = 1;
                    e_rdata = m_err ? 12'h000 : store[m_addr];
                    e_err   = m_err;
                end else if (aux_rready) begin
                    m_resp = 0;
                    m_busy = 0;
                end
            end
            if (gnt_e) begin
                m_busy = 1; m_addr = aux_addr; m_err = (aux_addr >= 16'(NPIX));
                m_wait = 0; m_denied = 0;
            end else if (!busy0 && (aux_req || m_wait)) begin
                if (m_wait) m_denied++;
                m_wait = 1;
            end
        end

        @(posedge clk);
        #1;
        chk("disp_pvalid", 32'(disp_pvalid), 32'(e_pvalid));
        chk("disp_pixel", 32'(disp_pixel), 32'(e_pix));
        chk("disp_miss", 32'(disp_miss), 32'(e_miss));
        chk("mem_en", 32'(mem_en), 32'(e_men));
        if (e_men) chk("mem_addr", 32'(mem_addr), 32'(e_maddr));
        chk("aux_rvalid", 32'(aux_rvalid), 32'(m_resp));
        if (m_resp) begin
            chk("aux_rdata", 32'(aux_rdata), 32'(e_rdata));
            chk("aux_err", 32'(aux_err), 32'(e_err));
        end
    endtask

    initial begin
        int gnt_at;
        int misses;

        for (int i = 0; i < NPIX; i++) store[i] = 12'($urandom);

        rst = 1; disp_req = 0; disp_haddr = '0; disp_vaddr = '0;
        aux_req = 0; aux_addr = '0; aux_rready = 0;
        cycle();
        disp_req = 1; aux_req = 1;   // activity during reset must be ignored
        cycle();
        chk("rst_gnt", 32'(last_gnt), 32'd0);
        chk("rst_pixel", 32'(disp_pixel), 32'd0);
        chk("rst_pvalid", 32'(disp_pvalid), 32'd0);
        chk("rst_miss", 32'(disp_miss), 32'd0);
        chk("rst_rvalid", 32'(aux_rvalid), 32'd0);
        chk("rst_rdata", 32'(aux_rdata), 32'd0);
        chk("rst_err", 32'(aux_err), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        rst = 0; aux_req = 0;

        // Display read at (5,2)
        disp_req = 1; disp_haddr = 11'd5; disp_vaddr = 11'd2;
        cycle();
        chk("d52_mem_en", 32'(mem_en), 32'd1);
        chk("d52_mem_addr", 32'(mem_addr), 32'd1285);
        cycle();
        chk("d52_pvalid", 32'(disp_pvalid), 32'd1);
        chk("d52_pixel", 32'(disp_pixel), 32'(store[1285]));

        // Out-of-range display coordinates
        disp_haddr = 11'd640; disp_vaddr = 11'd0;
        cycle();
        chk("h640_mem_en", 32'(mem_en), 32'd0);
        disp_haddr = 11'd0; disp_vaddr = 11'd60;
        cycle();
        chk("v60_mem_en", 32'(mem_en), 32'd0);
        chk("h640_pixel", 32'(disp_pixel), 32'd0);
        chk("h640_pvalid", 32'(disp_pvalid), 32'd1);
        disp_req = 0;
        cycle();
        chk("v60_pixel", 32'(disp_pixel), 32'd0);
        chk("v60_pvalid", 32'(disp_pvalid), 32'd1);

        // Aux read at index 100, with the consumer stalling
        aux_req = 1; aux_addr = 16'd100; aux_rready = 0;
        cycle();
        chk("a100_gnt", 32'(last_gnt), 32'd1);
        aux_req = 0;
        cycle();
        for (int i = 0; i < 4; i++) begin
            chk("a100_rvalid", 32'(aux_rvalid), 32'd1);
            chk("a100_rdata", 32'(aux_rdata), 32'(store[100]));
            cycle();
        end
        aux_rready = 1;
        cycle();
        chk("a100_done", 32'(aux_rvalid), 32'd0);

        // Aux index outside the image
        aux_req = 1; aux_addr = 16'd38400;
        cycle();
        chk("aoor_gnt", 32'(last_gnt), 32'd1);
        chk("aoor_mem_en", 32'(mem_en), 32'd0);
        aux_req = 0;
        cycle();
        chk("aoor_rvalid", 32'(aux_rvalid), 32'd1);
        chk("aoor_err", 32'(aux_err), 32'd1);
        chk("aoor_rdata", 32'(aux_rdata), 32'd0);
        cycle();

        // Continuous display traffic against a waiting aux request
        gnt_at = 0; misses = 0;
        disp_req = 1; disp_vaddr = 11'd1; aux_req = 1; aux_addr = 16'd200;
        for (int n = 1; n <= 30; n++) begin
            disp_haddr = 11'(n * 7);
            cycle();
            if (disp_miss) misses++;
            if (last_gnt && gnt_at == 0) begin
                gnt_at = n;
                aux_req = 0;
            end
        end
`ifdef STARVE_GUARD_EN
        chk("starve_gnt_cycle", 32'(gnt_at), 32'd17);
        chk("starve_misses", 32'(misses), 32'd1);
`else
        chk("noguard_no_gnt", 32'(gnt_at), 32'd0);
        chk("noguard_no_miss", 32'(misses), 32'd0);
        disp_req = 0;
        cycle();
        chk("noguard_gnt_free", 32'(last_gnt), 32'd1);
        aux_req = 0;
`endif
        disp_req = 0;
        for (int i = 0; i < 3; i++) cycle();

        // Reset while the aux read is in flight
        aux_req = 1; aux_addr = 16'd300;
        cycle();
        chk("rr_gnt", 32'(last_gnt), 32'd1);
        aux_req = 0; rst = 1;
        cycle();
        rst = 0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("rr_no_rvalid", 32'(aux_rvalid), 32'd0);
        end
        aux_req = 1; aux_addr = 16'd301;
        cycle();
        chk("rr2_gnt", 32'(last_gnt), 32'd1);
        aux_req = 0;
        cycle();
        chk("rr2_rvalid", 32'(aux_rvalid), 32'd1);
        chk("rr2_rdata", 32'(aux_rdata), 32'(store[301]));
        cycle();

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 299) == 0);
            disp_req = $urandom_range(0, 1) == 1;
            disp_haddr = ($urandom_range(0, 9) == 0) ? 11'(640 + $urandom_range(0, 60))
                                                      : 11'($urandom_range(0, 639));
            disp_vaddr = ($urandom_range(0, 9) == 0) ? 11'(60 + $urandom_range(0, 10))
                                                      : 11'($urandom_range(0, 59));
            if (aux_req && last_gnt) begin
                aux_req = 0;
            end else if (!aux_req && $urandom_range(0, 3) == 0) begin
                aux_req  = 1;
                aux_addr = ($urandom_range(0, 7) == 0) ? 16'(NPIX + $urandom_range(0, 999))
                                                        : 16'($urandom_range(0, NPIX - 1));
            end
            aux_rready = $urandom_range(0, 1) == 1;
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
